// File: rtl/regfile_mp_if.sv
// Bundle of read, write, scoreboard and dump-stream signals for regfile_mp.
// The master side drives addresses, write data, pend_set, halted and dump_ready.
interface regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    localparam int NREG = 2 ** AW;

    logic [AW-1:0]   rd_addr0, rd_addr1;
    logic [XLEN-1:0] rd_data0, rd_data1;
    logic            wr_en0, wr_en1;
    logic [AW-1:0]   wr_addr0, wr_addr1;
    logic [XLEN-1:0] wr_data0, wr_data1;
    logic            pend_set;
    logic [AW-1:0]   pend_addr;
    logic [NREG-1:0] pend;
    logic            halted;
    logic            dump_valid, dump_ready;
    logic [AW-1:0]   dump_idx;
    logic [XLEN-1:0] dump_data;
    logic            dump_done;

    modport master (
        output rd_addr0, rd_addr1, wr_en0, wr_en1, wr_addr0, wr_addr1,
               wr_data0, wr_data1, pend_set, pend_addr, halted, dump_ready,
        input  rd_data0, rd_data1, pend, dump_valid, dump_idx, dump_data, dump_done
    );

    modport slave (
        input  rd_addr0, rd_addr1, wr_en0, wr_en1, wr_addr0, wr_addr1,
               wr_data0, wr_data1, pend_set, pend_addr, halted, dump_ready,
        output rd_data0, rd_data1, pend, dump_valid, dump_idx, dump_data, dump_done
    );
endinterface

// File: rtl/regfile_mp.sv
// Two-read/two-write register file with pending scoreboard and a halt-triggered dump stream.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input logic         clk,
    input logic         rst_b,
    regfile_mp_if.slave bus
);
    localparam int NREG = 2 ** AW;

    typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            halted_q;
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pend_q, pend_d;
    logic            idle, we0, we1, pend_ok;

    // Register 0 is never written, so it holds its reset value of 0 forever.
    assign idle    = (state_q == IDLE);
    assign we0     = idle && bus.wr_en0 && (bus.wr_addr0 != '0);
    assign we1     = idle && bus.wr_en1 && (bus.wr_addr1 != '0);
    assign pend_ok = idle && bus.pend_set && (bus.pend_addr != '0);

    // NOTE: the array is reset because a post-reset dump must stream zeros;
    // a plain RAM macro would not give that, so this stays in flops.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (we0) regs[bus.wr_addr0] <= bus.wr_data0;
            if (we1) regs[bus.wr_addr1] <= bus.wr_data1;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign bus.rd_data0 = (we1 && bus.wr_addr1 == bus.rd_addr0) ? bus.wr_data1 :
                          (we0 && bus.wr_addr0 == bus.rd_addr0) ? bus.wr_data0 :
                          regs[bus.rd_addr0];
    assign bus.rd_data1 = (we1 && bus.wr_addr1 == bus.rd_addr1) ? bus.wr_data1 :
                          (we0 && bus.wr_addr0 == bus.rd_addr1) ? bus.wr_data0 :
                          regs[bus.rd_addr1];
`else
    assign bus.rd_data0 = regs[bus.rd_addr0];
    assign bus.rd_data1 = regs[bus.rd_addr1];
`endif

    // Clears first so a same-cycle set on the same register wins.
    always_comb begin
        pend_d = pend_q;
        if (we0)     pend_d[bus.wr_addr0] = 1'b0;
        if (we1)     pend_d[bus.wr_addr1] = 1'b0;
        if (pend_ok) pend_d[bus.pend_addr] = 1'b1;
        pend_d[0] = 1'b0;
    end

    assign bus.pend = pend_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            halted_q <= 1'b0;
            pend_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            halted_q <= bus.halted;
            pend_q   <= pend_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        bus.dump_valid = 1'b0;
        bus.dump_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.halted && !halted_q) begin
                    state_d = DUMP;
                    idx_d   = '0;
                end
            end
            DUMP: begin
                bus.dump_valid = 1'b1;
                if (bus.dump_ready) begin
                    if (&idx_q) state_d = DONE;
                    else        idx_d   = idx_q + 1'b1;
                end
            end
            DONE: begin
                bus.dump_done = 1'b1;
                if (!bus.halted) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registers cannot change outside IDLE, so index and data hold while stalled.
    assign bus.dump_idx  = idx_q;
    assign bus.dump_data = regs[idx_q];
endmodule
